// File: rtl/cnn_layer_accel_synch_pkg.sv
// ---------------------------------------------------------------------------
// cnn_layer_accel_synch_pkg
// Shared definitions for the CNN layer accelerator synchronisation barrier:
//   - default parameter constants
//   - barrier FSM state encoding
//   - all_arrived(): completion test of an arrival vector against a mask
// Vectors passed to all_arrived() are zero-extended to C_MAX_CHAN bits by the
// caller, so one function serves every channel count from 1 to 32.
// ---------------------------------------------------------------------------
package cnn_layer_accel_synch_pkg;

  localparam int unsigned C_MAX_CHAN      = 32;
  localparam int unsigned C_DEF_NUM_CHAN  = 8;
  localparam int unsigned C_DEF_TO_WIDTH  = 16;
  localparam int unsigned C_DEF_GEN_WIDTH = 4;
  localparam int unsigned C_ERR_CNT_WIDTH = 8;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ARM     = 3'd1,
    ST_WAIT    = 3'd2,
    ST_RELEASE = 3'd3,
    ST_ERR     = 3'd4
  } state_t;

  // True when every channel enabled in mask is also set in vec.
  // An all-zero mask is trivially complete.
  function automatic logic all_arrived(input logic [C_MAX_CHAN-1:0] mask,
                                       input logic [C_MAX_CHAN-1:0] vec);
    return (mask & ~vec) == '0;
  endfunction

endpackage

// File: rtl/cnn_layer_accel_synch_timer.sv
// ---------------------------------------------------------------------------
// cnn_layer_accel_synch_timer
// Loadable up-counter with compare-and-fire output.
//   clk    : clock, posedge
//   rst    : asynchronous active-low reset, clears the count
//   clr    : synchronous clear to zero (has priority over en)
//   en     : increment by one this cycle (saturates at all-ones)
//   limit  : compare value; 0 disables fire
//   count  : current count (registered)
//   fire   : count == limit-1 while limit != 0 (combinational on the count)
// fire flags the last counted cycle so the owner can act on the same edge
// that would otherwise take the count to limit.
// ---------------------------------------------------------------------------
module cnn_layer_accel_synch_timer #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         en,
  input  logic [W-1:0] limit,
  output logic [W-1:0] count,
  output logic         fire
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en && (cnt_q != {W{1'b1}})) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign count = cnt_q;
  assign fire  = (limit != '0) && (cnt_q == (limit - W'(1)));

endmodule

// File: rtl/cnn_layer_accel_synch_barrier.sv
// ---------------------------------------------------------------------------
// cnn_layer_accel_synch_barrier
// Multi-channel synchronisation barrier for the accelerator core clock domain.
// A start pulse (accepted only in IDLE) latches the channel mask and timeout;
// per-channel arrival pulses are collected until every enabled channel has
// arrived, then a one-cycle release pulse is emitted with a generation tag.
// A nonzero timeout bounds the wait; expiry latches an error and the vector
// of channels that never arrived until clear_err.
//
// Ports:
//   clk_core         core clock, posedge
//   rst              asynchronous active-low reset
//   cfg_chan_mask    enabled channels, sampled on accepted start
//   cfg_timeout      wait limit in cycles (0 = none), sampled on accepted start
//   start            arm pulse
//   chan_arrive      per-channel arrival pulses
//   clear_err        leave the error state
//   busy             high outside IDLE
//   release_pulse    one-cycle barrier release
//   release_gen      generation of the most recent release (wraps)
//   arrived_vec      sticky masked arrivals of the current barrier
//   timeout_err      high while in the error state
//   missing_vec      mask & ~arrived, frozen at timeout
//   last_wait_cycles ARM..RELEASE cycle count, saturating   (stats build only)
//   err_count        number of timeouts, saturating at 255  (stats build only)
//
// Optional statistics: define CNN_LAYER_ACCEL_SYNCH_BARRIER_STATS_EN.
//
// Interface semantics: there is no valid/ready handshake. start, chan_arrive
// and clear_err are level-sampled pulses, one event per cycle they are high;
// release_pulse is a one-cycle strobe with no back-pressure.
//
// The state is held in state_q; busy_q and timeout_err_q are registered
// decodes of it for observation.
// ---------------------------------------------------------------------------
module cnn_layer_accel_synch_barrier
  import cnn_layer_accel_synch_pkg::*;
#(
  parameter int unsigned C_NUM_CHAN  = C_DEF_NUM_CHAN,
  parameter int unsigned C_TO_WIDTH  = C_DEF_TO_WIDTH,
  parameter int unsigned C_GEN_WIDTH = C_DEF_GEN_WIDTH
) (
  input  logic                   clk_core,
  input  logic                   rst,
  input  logic [C_NUM_CHAN-1:0]  cfg_chan_mask,
  input  logic [C_TO_WIDTH-1:0]  cfg_timeout,
  input  logic                   start,
  input  logic [C_NUM_CHAN-1:0]  chan_arrive,
  input  logic                   clear_err,
  output logic                   busy,
  output logic                   release_pulse,
  output logic [C_GEN_WIDTH-1:0] release_gen,
  output logic [C_NUM_CHAN-1:0]  arrived_vec,
  output logic                   timeout_err,
  output logic [C_NUM_CHAN-1:0]  missing_vec
`ifdef CNN_LAYER_ACCEL_SYNCH_BARRIER_STATS_EN
  ,
  output logic [C_TO_WIDTH-1:0]      last_wait_cycles,
  output logic [C_ERR_CNT_WIDTH-1:0] err_count
`endif
);

  state_t                 state_q,       state_d;
  logic [C_NUM_CHAN-1:0]  mask_q,        mask_d;
  logic [C_TO_WIDTH-1:0]  timeout_q,     timeout_d;
  logic [C_NUM_CHAN-1:0]  arrived_q,     arrived_d;
  logic [C_NUM_CHAN-1:0]  missing_q,     missing_d;
  logic [C_GEN_WIDTH-1:0] gen_q,         gen_d;
  logic                   busy_q,        busy_d;
  logic                   release_q,     release_d;
  logic                   timeout_err_q, timeout_err_d;
  // Arrivals during ARM/WAIT pass through one input register; the start
  // cycle itself samples chan_arrive directly so same-cycle arrivals count.
  logic [C_NUM_CHAN-1:0]  arr_q;

  logic                   start_ok;
  logic [C_NUM_CHAN-1:0]  arrived_upd;
  logic [C_MAX_CHAN-1:0]  mask_ext;
  logic [C_MAX_CHAN-1:0]  arrived_ext;
  logic [C_MAX_CHAN-1:0]  upd_ext;
  logic                   tmr_fire;
  logic [C_TO_WIDTH-1:0]  tmr_count_unused;

  cnn_layer_accel_synch_timer #(
    .W (C_TO_WIDTH)
  ) u_wait_timer (
    .clk   (clk_core),
    .rst   (rst),
    .clr   (start_ok),
    .en    (state_q == ST_WAIT),
    .limit (timeout_q),
    .count (tmr_count_unused),
    .fire  (tmr_fire)
  );

  always_comb begin
    start_ok    = (state_q == ST_IDLE) && start;
    arrived_upd = arrived_q | (arr_q & mask_q);
    mask_ext    = '0;
    arrived_ext = '0;
    upd_ext     = '0;
    mask_ext[C_NUM_CHAN-1:0]    = mask_q;
    arrived_ext[C_NUM_CHAN-1:0] = arrived_q;
    upd_ext[C_NUM_CHAN-1:0]     = arrived_upd;

    state_d   = state_q;
    mask_d    = mask_q;
    timeout_d = timeout_q;
    arrived_d = arrived_q;
    missing_d = missing_q;
    gen_d     = gen_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          mask_d    = cfg_chan_mask;
          timeout_d = cfg_timeout;
          arrived_d = chan_arrive & cfg_chan_mask;
          missing_d = '0;
          state_d   = ST_ARM;
        end
      end
      ST_ARM: begin
        state_d = all_arrived(mask_ext, arrived_ext) ? ST_RELEASE : ST_WAIT;
      end
      ST_WAIT: begin
        arrived_d = arrived_upd;
        // Completion is tested first so it wins over a same-cycle timeout.
        if (all_arrived(mask_ext, upd_ext)) begin
          state_d = ST_RELEASE;
        end else if (tmr_fire) begin
          state_d   = ST_ERR;
          missing_d = mask_q & ~arrived_upd;
        end
      end
      ST_RELEASE: begin
        state_d = ST_IDLE;
      end
      ST_ERR: begin
        if (clear_err) begin
          state_d   = ST_IDLE;
          arrived_d = '0;
          missing_d = '0;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Outputs are registered decodes of the next state.
    busy_d        = (state_d != ST_IDLE);
    release_d     = (state_d == ST_RELEASE);
    timeout_err_d = (state_d == ST_ERR);
    if (state_d == ST_RELEASE) begin
      gen_d = gen_q + C_GEN_WIDTH'(1);
    end
  end

  always_ff @(posedge clk_core or negedge rst) begin
    if (!rst) begin
      state_q       <= ST_IDLE;
      mask_q        <= '0;
      timeout_q     <= '0;
      arrived_q     <= '0;
      missing_q     <= '0;
      gen_q         <= '0;
      busy_q        <= 1'b0;
      release_q     <= 1'b0;
      timeout_err_q <= 1'b0;
      arr_q         <= '0;
    end else begin
      state_q       <= state_d;
      mask_q        <= mask_d;
      timeout_q     <= timeout_d;
      arrived_q     <= arrived_d;
      missing_q     <= missing_d;
      gen_q         <= gen_d;
      busy_q        <= busy_d;
      release_q     <= release_d;
      timeout_err_q <= timeout_err_d;
      arr_q         <= chan_arrive;
    end
  end

  assign busy          = busy_q;
  assign release_pulse = release_q;
  assign release_gen   = gen_q;
  assign arrived_vec   = arrived_q;
  assign timeout_err   = timeout_err_q;
  assign missing_vec   = missing_q;

`ifdef CNN_LAYER_ACCEL_SYNCH_BARRIER_STATS_EN
  logic [C_TO_WIDTH-1:0]      stat_count;
  logic                       stat_fire_unused;
  logic [C_TO_WIDTH-1:0]      last_wait_q, last_wait_d;
  logic [C_ERR_CNT_WIDTH-1:0] err_cnt_q,   err_cnt_d;

  // Counts every ARM and WAIT cycle of the current barrier; the timer
  // saturates at all-ones, which gives the required saturating behaviour.
  cnn_layer_accel_synch_timer #(
    .W (C_TO_WIDTH)
  ) u_stat_timer (
    .clk   (clk_core),
    .rst   (rst),
    .clr   (start_ok),
    .en    ((state_q == ST_ARM) || (state_q == ST_WAIT)),
    .limit ('0),
    .count (stat_count),
    .fire  (stat_fire_unused)
  );

  always_comb begin
    last_wait_d = last_wait_q;
    err_cnt_d   = err_cnt_q;
    if (state_q == ST_RELEASE) begin
      last_wait_d = stat_count;
    end
    if ((state_d == ST_ERR) && (state_q != ST_ERR) && (err_cnt_q != '1)) begin
      err_cnt_d = err_cnt_q + C_ERR_CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge clk_core or negedge rst) begin
    if (!rst) begin
      last_wait_q <= '0;
      err_cnt_q   <= '0;
    end else begin
      last_wait_q <= last_wait_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  assign last_wait_cycles = last_wait_q;
  assign err_count        = err_cnt_q;
`endif

endmodule
